// File: rtl/ahb_slave_if.sv
// AHB-side front end of the AHB-to-APB bridge: transfer qualification, slave decode, 2-deep pipeline.
// Define AHB_ERR_RESP_EN to build the two-cycle ERROR response FSM; otherwise illegal transfers are dropped.
module ahb_slave_if #(
  parameter logic [31:0] SLV0_BASE   = 32'h8000_0000,
  parameter logic [31:0] SLV1_BASE   = 32'h8400_0000,
  parameter logic [31:0] SLV2_BASE   = 32'h8800_0000,
  parameter int          REGION_LOG2 = 26
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hreadyin,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hsize,
  input  logic        hwrite,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  input  logic [31:0] prdata,
  input  logic        hr_readyout,
  output logic        valid,
  output logic [2:0]  temp_sel,
  output logic [31:0] haddr1,
  output logic [31:0] haddr2,
  output logic [31:0] hwdata1,
  output logic [31:0] hwdata2,
  output logic        hwrite_reg1,
  output logic        hwrite_reg2,
  output logic [31:0] hrdata,
  output logic [1:0]  hresp,
  output logic        hreadyout
);

  logic active;
  logic bad;

  assign active = htrans[1];
  assign hrdata = prdata;

  always_comb begin
    temp_sel = 3'b000;
    if (haddr[31:REGION_LOG2] == SLV0_BASE[31:REGION_LOG2])
      temp_sel = 3'b001;
    else if (haddr[31:REGION_LOG2] == SLV1_BASE[31:REGION_LOG2])
      temp_sel = 3'b010;
    else if (haddr[31:REGION_LOG2] == SLV2_BASE[31:REGION_LOG2])
      temp_sel = 3'b100;
  end

  // Unmapped address, oversize transfer, or size/alignment mismatch.
  always_comb begin
    bad = 1'b0;
    if (temp_sel == 3'b000)
      bad = 1'b1;
    if (hsize > 3'b010)
      bad = 1'b1;
    if ((hsize == 3'b010) && (haddr[1:0] != 2'b00))
      bad = 1'b1;
    if ((hsize == 3'b001) && haddr[0])
      bad = 1'b1;
  end

  // Stages advance on every accepted bus cycle, independent of valid.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      haddr1      <= '0;
      haddr2      <= '0;
      hwdata1     <= '0;
      hwdata2     <= '0;
      hwrite_reg1 <= 1'b0;
      hwrite_reg2 <= 1'b0;
    end else if (hreadyin) begin
      haddr1      <= haddr;
      haddr2      <= haddr1;
      hwdata1     <= hwdata;
      hwdata2     <= hwdata1;
      hwrite_reg1 <= hwrite;
      hwrite_reg2 <= hwrite_reg1;
    end
  end

`ifdef AHB_ERR_RESP_EN
  // state   | meaning
  // OK_ST   | normal operation, ready follows the APB controller
  // ERR1_ST | first ERROR cycle, bus stalled
  // ERR2_ST | second ERROR cycle, bus released; next address phase accepted
  typedef enum logic [1:0] {OK_ST, ERR1_ST, ERR2_ST} state_t;
  state_t state, state_next;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state <= OK_ST;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      OK_ST:   if (hreadyin && active && bad) state_next = ERR1_ST;
      ERR1_ST: state_next = ERR2_ST;
      ERR2_ST: state_next = (hreadyin && active && bad) ? ERR1_ST : OK_ST;
      default: state_next = OK_ST;
    endcase
  end

  always_comb begin
    hresp     = 2'b00;
    hreadyout = hr_readyout;
    case (state)
      ERR1_ST: begin hresp = 2'b01; hreadyout = 1'b0; end
      ERR2_ST: begin hresp = 2'b01; hreadyout = 1'b1; end
      default: begin hresp = 2'b00; hreadyout = hr_readyout; end
    endcase
  end

  assign valid = hreadyin & active & ~bad & (state != ERR1_ST);
`else
  assign hresp     = 2'b00;
  assign hreadyout = hr_readyout;
  assign valid     = hreadyin & active & ~bad;
`endif

endmodule

// File: tb/tb_ahb_slave_if.sv
// Directed self-checking bench for ahb_slave_if; ERROR expectations follow AHB_ERR_RESP_EN.
module tb_ahb_slave_if;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hreadyin;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [31:0] prdata;
  logic        hr_readyout;
  logic        valid;
  logic [2:0]  temp_sel;
  logic [31:0] haddr1, haddr2, hwdata1, hwdata2, hrdata;
  logic        hwrite_reg1, hwrite_reg2;
  logic [1:0]  hresp;
  logic        hreadyout;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef AHB_ERR_RESP_EN
  localparam logic [1:0] ERR_RESP = 2'b01;
  localparam logic       ERR1_RDY = 1'b0;
`else
  localparam logic [1:0] ERR_RESP = 2'b00;
  localparam logic       ERR1_RDY = 1'b1;
`endif

  ahb_slave_if dut (
    .hclk(hclk), .hresetn(hresetn), .hreadyin(hreadyin), .htrans(htrans),
    .hsize(hsize), .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata),
    .prdata(prdata), .hr_readyout(hr_readyout), .valid(valid), .temp_sel(temp_sel),
    .haddr1(haddr1), .haddr2(haddr2), .hwdata1(hwdata1), .hwdata2(hwdata2),
    .hwrite_reg1(hwrite_reg1), .hwrite_reg2(hwrite_reg2), .hrdata(hrdata),
    .hresp(hresp), .hreadyout(hreadyout)
  );

  always #5 hclk = ~hclk;

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic go_idle();
    htrans = 2'b00; hreadyin = 1'b1; hwrite = 1'b0; hsize = 3'b010; haddr = '0;
  endtask

  task automatic test_reset();
    haddr = 32'h1234_5678; hwrite = 1'b1; hwdata = 32'h0000_A5A5;
    step();
    n_checks++; if (haddr1 !== 32'h1234_5678) begin n_fail++; $display("FAIL rst_pre_haddr1: got %h exp 12345678", haddr1); end
    step();
    #2 hresetn = 1'b0;
    #1;
    n_checks++; if (haddr1 !== 32'h0) begin n_fail++; $display("FAIL rst_haddr1: got %h exp 0", haddr1); end
    n_checks++; if (haddr2 !== 32'h0) begin n_fail++; $display("FAIL rst_haddr2: got %h exp 0", haddr2); end
    n_checks++; if (hwdata1 !== 32'h0 || hwdata2 !== 32'h0) begin n_fail++; $display("FAIL rst_hwdata: got %h/%h exp 0/0", hwdata1, hwdata2); end
    n_checks++; if (hwrite_reg1 !== 1'b0 || hwrite_reg2 !== 1'b0) begin n_fail++; $display("FAIL rst_hwrite: got %b/%b exp 0/0", hwrite_reg1, hwrite_reg2); end
    n_checks++; if (hresp !== 2'b00 || hreadyout !== 1'b1) begin n_fail++; $display("FAIL rst_resp: got %b/%b exp 00/1", hresp, hreadyout); end
    #3 hresetn = 1'b1;
    hwdata = '0;
    go_idle();
    step();
  endtask

  task automatic test_write();
    haddr = 32'h8400_0010; htrans = 2'b10; hsize = 3'b010; hwrite = 1'b1; hwdata = 32'h1111_1111;
    #1;
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL wr_valid: got %b exp 1", valid); end
    n_checks++; if (temp_sel !== 3'b010) begin n_fail++; $display("FAIL wr_sel: got %b exp 010", temp_sel); end
    step();
    n_checks++; if (haddr1 !== 32'h8400_0010 || hwrite_reg1 !== 1'b1) begin n_fail++; $display("FAIL wr_stage1: got %h/%b exp 84000010/1", haddr1, hwrite_reg1); end
    htrans = 2'b00; haddr = '0; hwrite = 1'b0; hwdata = 32'hCAFE_0001;
    #1;
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL wr_idle_valid: got %b exp 0", valid); end
    step();
    n_checks++; if (haddr2 !== 32'h8400_0010) begin n_fail++; $display("FAIL wr_haddr2: got %h exp 84000010", haddr2); end
    n_checks++; if (hwdata1 !== 32'hCAFE_0001) begin n_fail++; $display("FAIL wr_hwdata1: got %h exp cafe0001", hwdata1); end
    n_checks++; if (hwrite_reg2 !== 1'b1 || hwrite_reg1 !== 1'b0) begin n_fail++; $display("FAIL wr_hwrite: got r1=%b r2=%b exp 0/1", hwrite_reg1, hwrite_reg2); end
    go_idle();
    step();
    step();
  endtask

  task automatic test_back_to_back();
    haddr = 32'h8000_0000; htrans = 2'b11; hwrite = 1'b1; hwdata = 32'hD000_0000; hreadyin = 1'b1;
    #1;
    n_checks++; if (valid !== 1'b1 || temp_sel !== 3'b001) begin n_fail++; $display("FAIL b2b_a_valid: got %b/%b exp 1/001", valid, temp_sel); end
    step();
    n_checks++; if (haddr1 !== 32'h8000_0000 || hwrite_reg1 !== 1'b1 || hwrite_reg2 !== 1'b0) begin n_fail++; $display("FAIL b2b_a_stage: got %h %b %b exp 80000000 1 0", haddr1, hwrite_reg1, hwrite_reg2); end
    haddr = 32'h8000_0004; hwdata = 32'hD000_0001; hreadyin = 1'b0;
    #1;
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL b2b_b_valid: got %b exp 0", valid); end
    step();
    n_checks++; if (haddr1 !== 32'h8000_0000 || haddr2 !== 32'h0) begin n_fail++; $display("FAIL b2b_hold_addr: got %h/%h exp 80000000/0", haddr1, haddr2); end
    n_checks++; if (hwdata1 !== 32'hD000_0000 || hwrite_reg2 !== 1'b0) begin n_fail++; $display("FAIL b2b_hold_data: got %h/%b exp d0000000/0", hwdata1, hwrite_reg2); end
    haddr = 32'h8000_0008; hwdata = 32'hD000_0002; hreadyin = 1'b1;
    #1;
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL b2b_c_valid: got %b exp 1", valid); end
    step();
    n_checks++; if (haddr1 !== 32'h8000_0008 || haddr2 !== 32'h8000_0000) begin n_fail++; $display("FAIL b2b_c_addr: got %h/%h exp 80000008/80000000", haddr1, haddr2); end
    n_checks++; if (hwdata1 !== 32'hD000_0002 || hwdata2 !== 32'hD000_0000) begin n_fail++; $display("FAIL b2b_c_data: got %h/%h exp d0000002/d0000000", hwdata1, hwdata2); end
    n_checks++; if (hwrite_reg2 !== 1'b1) begin n_fail++; $display("FAIL b2b_hwrite_reg2: got %b exp 1", hwrite_reg2); end
    go_idle();
    step();
  endtask

  task automatic test_error_decode();
    haddr = 32'h9000_0000; htrans = 2'b10; hsize = 3'b010;
    #1;
    n_checks++; if (valid !== 1'b0 || temp_sel !== 3'b000) begin n_fail++; $display("FAIL err_dec_valid: got %b/%b exp 0/000", valid, temp_sel); end
    step();
    go_idle();
    #1;
    n_checks++; if (hresp !== ERR_RESP || hreadyout !== ERR1_RDY) begin n_fail++; $display("FAIL err_dec_cyc1: got %b/%b exp %b/%b", hresp, hreadyout, ERR_RESP, ERR1_RDY); end
    step();
    // Second ERROR cycle: a new legal address phase must be accepted.
    haddr = 32'h8000_0000; htrans = 2'b10;
    #1;
    n_checks++; if (hresp !== ERR_RESP || hreadyout !== 1'b1) begin n_fail++; $display("FAIL err_dec_cyc2: got %b/%b exp %b/1", hresp, hreadyout, ERR_RESP); end
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL err_dec_accept: got %b exp 1", valid); end
    step();
    go_idle();
    #1;
    n_checks++; if (hresp !== 2'b00 || hreadyout !== 1'b1) begin n_fail++; $display("FAIL err_dec_done: got %b/%b exp 00/1", hresp, hreadyout); end
    step();
  endtask

  task automatic test_misaligned();
    haddr = 32'h8800_0002; htrans = 2'b10; hsize = 3'b001; hwrite = 1'b0;
    #1;
    n_checks++; if (valid !== 1'b1 || temp_sel !== 3'b100) begin n_fail++; $display("FAIL mis_half_ok: got %b/%b exp 1/100", valid, temp_sel); end
    hsize = 3'b011;
    #1;
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL mis_oversize: got %b exp 0", valid); end
    haddr = 32'h8800_0001; hsize = 3'b001;
    #1;
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL mis_half_odd: got %b exp 0", valid); end
    haddr = 32'h8800_0002; hsize = 3'b010;
    #1;
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL mis_word: got %b exp 0", valid); end
    step();
    go_idle();
    #1;
    n_checks++; if (hresp !== ERR_RESP || hreadyout !== ERR1_RDY) begin n_fail++; $display("FAIL mis_cyc1: got %b/%b exp %b/%b", hresp, hreadyout, ERR_RESP, ERR1_RDY); end
    step();
    n_checks++; if (hresp !== ERR_RESP || hreadyout !== 1'b1) begin n_fail++; $display("FAIL mis_cyc2: got %b/%b exp %b/1", hresp, hreadyout, ERR_RESP); end
    step();
    n_checks++; if (hresp !== 2'b00) begin n_fail++; $display("FAIL mis_done: got %b exp 00", hresp); end
  endtask

  task automatic test_busy();
    haddr = 32'h8000_0000; htrans = 2'b01; hsize = 3'b010; prdata = 32'hDEAD_BEEF;
    #1;
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL busy_valid: got %b exp 0", valid); end
    n_checks++; if (hrdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL busy_hrdata: got %h exp deadbeef", hrdata); end
    step();
    n_checks++; if (hresp !== 2'b00 || hreadyout !== 1'b1) begin n_fail++; $display("FAIL busy_resp: got %b/%b exp 00/1", hresp, hreadyout); end
    // Controller stalls: a bad address phase is not sampled while hreadyin is low.
    hr_readyout = 1'b0; hreadyin = 1'b0; haddr = 32'h9000_0000; htrans = 2'b10;
    #1;
    n_checks++; if (hreadyout !== 1'b0 || valid !== 1'b0) begin n_fail++; $display("FAIL stall_ready: got %b/%b exp 0/0", hreadyout, valid); end
    step();
    n_checks++; if (hresp !== 2'b00 || hreadyout !== 1'b0) begin n_fail++; $display("FAIL stall_noerr: got %b/%b exp 00/0", hresp, hreadyout); end
    hr_readyout = 1'b1;
    go_idle();
    step();
  endtask

  initial begin
    hresetn = 1'b0; hreadyin = 1'b1; htrans = 2'b00; hsize = 3'b010; hwrite = 1'b0;
    haddr = '0; hwdata = '0; prdata = '0; hr_readyout = 1'b1;
    #12 hresetn = 1'b1;
    test_reset();
    test_write();
    test_back_to_back();
    test_error_decode();
    test_misaligned();
    test_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
